rom_load_sequencer: RTL

- Sequences HPS ROM download traffic (ioctl_*) into the core's ROM write port (dn_*).
- Holds the core in reset for the whole load.
- Decodes the byte address into one of four ROM region selects and counts bytes.
- Releases core reset a fixed number of cycles after the download ends, or holds it on error.
- Sits between hps_io and the Asteroids core top, in the clk_25 domain.

---
 rtl/rom_load_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rom_load_sequencer.sv
// Steers HPS ROM download bytes onto the core ROM write port and holds core reset across the load.
// Optional checksum gate via `define ROM_CSUM_EN (adds csum_ok).
module rom_load_sequencer #(
  parameter logic [15:0] R0_END      = 16'h07FF,
  parameter logic [15:0] R1_END      = 16'h0FFF,
  parameter logic [15:0] R2_END      = 16'h17FF,
  parameter logic [15:0] R3_END      = 16'h1FFF,
`ifdef ROM_CSUM_EN
  parameter logic [7:0]  EXP_SUM     = 8'h00,
`endif
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [3:0]  dn_cs,
  output logic        core_reset,
  output logic        busy,
  output logic        err_ovf,
  output logic [15:0] byte_cnt
`ifdef ROM_CSUM_EN
  ,
  output logic        csum_ok
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, ERR} state_t;

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic               dl_q;
  logic               dl_rise_c;
  logic               dl_fall_c;
  logic               in_range_c;
  logic               load_go_c;
  logic               hold_err_c;
  logic [3:0]         region_cs_c;
`ifdef ROM_CSUM_EN
  logic [7:0]         sum;
`endif

  assign dl_rise_c  = ioctl_download & ~dl_q;
  assign dl_fall_c  = ~ioctl_download & dl_q;
  assign in_range_c = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] <= R3_END);
  assign load_go_c  = dl_rise_c && (state != LOAD);

`ifdef ROM_CSUM_EN
  assign hold_err_c = err_ovf || (sum != EXP_SUM);
`else
  assign hold_err_c = err_ovf;
`endif

  // Lowest region whose end address covers the byte
  always_comb begin
    region_cs_c = 4'b1000;
    if (ioctl_addr[15:0] <= R0_END)      region_cs_c = 4'b0001;
    else if (ioctl_addr[15:0] <= R1_END) region_cs_c = 4'b0010;
    else if (ioctl_addr[15:0] <= R2_END) region_cs_c = 4'b0100;
  end

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= CNT_W'(HOLD_CYCLES);
      dl_q       <= 1'b0;
      dn_addr    <= 16'd0;
      dn_data    <= 8'd0;
      dn_wr      <= 1'b0;
      dn_cs      <= 4'd0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      err_ovf    <= 1'b0;
      byte_cnt   <= 16'd0;
`ifdef ROM_CSUM_EN
      sum        <= 8'd0;
      csum_ok    <= 1'b0;
`endif
    end else begin
      dl_q  <= ioctl_download;
      dn_wr <= 1'b0;
      dn_cs <= 4'd0;
      if (load_go_c) begin
        // Any non-LOAD state restarts a load on a fresh download edge
        state      <= LOAD;
        busy       <= 1'b1;
        core_reset <= 1'b1;
        byte_cnt   <= 16'd0;
        err_ovf    <= 1'b0;
`ifdef ROM_CSUM_EN
        sum        <= 8'd0;
`endif
      end else begin
        case (state)
          IDLE: begin
            core_reset <= 1'b0;
            busy       <= 1'b0;
          end
          LOAD: begin
            core_reset <= 1'b1;
            busy       <= 1'b1;
            if (ioctl_wr) begin
              if (in_range_c) begin
                dn_wr   <= 1'b1;
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
                dn_cs   <= region_cs_c;
                if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
`ifdef ROM_CSUM_EN
                sum     <= sum + ioctl_dout;
`endif
              end else begin
                err_ovf <= 1'b1;
              end
            end
            if (dl_fall_c) begin
              state    <= HOLD;
              hold_cnt <= CNT_W'(HOLD_CYCLES);
            end
          end
          HOLD: begin
            core_reset <= 1'b1;
            busy       <= 1'b1;
            // Exit on the cycle that completes HOLD_CYCLES cycles of held reset
            if (hold_cnt <= CNT_W'(1)) begin
              busy <= 1'b0;
`ifdef ROM_CSUM_EN
              csum_ok <= (sum == EXP_SUM);
`endif
              if (hold_err_c) begin
                state <= ERR;
              end else begin
                state      <= IDLE;
                core_reset <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt - CNT_W'(1);
            end
          end
          ERR: begin
            core_reset <= 1'b1;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
